// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 serial transmitter snooping the CPU data-write bus.
// Bytes written to ADDR are queued in a small FIFO; the status word sits at ADDR+1.
module io_uart_tx #(
   parameter logic [15:0] ADDR  = 16'hff00,
   parameter int unsigned DIV   = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] dwrite_addr,
   input  logic [15:0] dwrite_data,
   input  logic [1:0]  dwrite_en,
   input  logic [15:0] dread_addr,
   output logic        status_sel,
   output logic [15:0] status_data,
   output logic        txd
);

   localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH) + 1;
   localparam logic [15:0] StatAddr = ADDR + 16'd1;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e            state_q, state_d;
   logic [DivW-1:0]   div_q, div_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              txd_q, txd_d;
   logic              overflow_q, overflow_d;
   logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [7:0]        mem_q [DEPTH];

   logic [15:0] addr_p1;
   logic        lo_hit, hi_hit, push_hit, push_ok, stat_hit, pop;
   logic        fifo_empty, fifo_full, div_last;
   logic [7:0]  push_byte, head;

   assign addr_p1    = dwrite_addr + 16'd1;
   assign lo_hit     = dwrite_en[0] && (dwrite_addr == ADDR);
   assign hi_hit     = dwrite_en[1] && (addr_p1 == ADDR);
   assign push_hit   = lo_hit || hi_hit;
   assign push_byte  = lo_hit ? dwrite_data[7:0] : dwrite_data[15:8];
   assign stat_hit   = (dwrite_en[0] && (dwrite_addr == StatAddr)) ||
                       (dwrite_en[1] && (addr_p1 == StatAddr));
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CntW'(DEPTH));
   assign head       = mem_q[rptr_q];
   assign div_last   = (div_q == DivW'(DIV - 1));

   // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
   assign push_ok = push_hit && (!fifo_full || pop);

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      txd_d   = txd_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = head;
               txd_d   = 1'b0;
               div_d   = '0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (div_last) begin
               div_d   = '0;
               bit_d   = '0;
               txd_d   = shift_q[0];
               state_d = StData;
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         StData: begin
            if (div_last) begin
               div_d   = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  txd_d   = 1'b1;
                  state_d = StStop;
               end else begin
                  bit_d = bit_q + 3'd1;
                  txd_d = shift_q[1];
               end
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         StStop: begin
            if (div_last) begin
               div_d = '0;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  txd_d   = 1'b0;
                  state_d = StStart;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push_ok) wptr_d = wptr_q + PtrW'(1);
      if (pop)     rptr_d = rptr_q + PtrW'(1);
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
      if (stat_hit) overflow_d = 1'b0;
      // A dropped byte is reported even if the status register is written in the same cycle.
      if (push_hit && !push_ok) overflow_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         div_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         txd_q      <= 1'b1;
         overflow_q <= 1'b0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         txd_q      <= txd_d;
         overflow_q <= overflow_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (push_ok) begin
         mem_q[wptr_q] <= push_byte;
      end
   end

   assign txd         = txd_q;
   assign status_sel  = (dread_addr == StatAddr);
   assign status_data = {12'b0, overflow_q, fifo_full, fifo_empty, state_q != StIdle};

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx with DIV=4, DEPTH=4, ADDR=16'hff00.
module tb_io_uart_tx;

   logic        clk;
   logic        reset;
   logic [15:0] dwrite_addr;
   logic [15:0] dwrite_data;
   logic [1:0]  dwrite_en;
   logic [15:0] dread_addr;
   logic        status_sel;
   logic [15:0] status_data;
   logic        txd;

   int total = 0;
   int bad   = 0;

   io_uart_tx #(.ADDR(16'hff00), .DIV(4), .DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .dwrite_addr (dwrite_addr),
      .dwrite_data (dwrite_data),
      .dwrite_en   (dwrite_en),
      .dread_addr  (dread_addr),
      .status_sel  (status_sel),
      .status_data (status_data),
      .txd         (txd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected txd at cycle pos (0..39) of a frame: 4-cycle start, 8 data bits LSB first, stop.
   function automatic logic exp_bit(input logic [7:0] b, input int pos);
      if (pos < 4) return 1'b0;
      if (pos >= 36) return 1'b1;
      return b[(pos - 4) / 4];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_bus(input logic [15:0] a, input logic [15:0] d, input logic [1:0] e);
      dwrite_addr = a;
      dwrite_data = d;
      dwrite_en   = e;
   endtask

   // Write at edge E0, then capture the 40 txd samples following E1..E40.
   task automatic send_and_check(input logic [15:0] a, input logic [15:0] d,
                                 input logic [1:0] e, input logic [7:0] b, input string nm);
      logic [39:0] cap, exp;
      logic busy_first, busy_last;
      set_bus(a, d, e);
      tick();
      dwrite_en = 2'b00;
      total++;
      if (status_data !== 16'h0000) begin
         bad++;
         $display("FAIL %s_queued: status_data=%h required 0000", nm, status_data);
      end
      busy_first = 1'b0;
      busy_last  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         cap[i] = txd;
         exp[i] = exp_bit(b, i);
         if (i == 0)  busy_first = status_data[0];
         if (i == 39) busy_last  = status_data[0];
      end
      total++;
      if (cap !== exp) begin
         bad++;
         $display("FAIL %s_frame: txd samples=%h required %h", nm, cap, exp);
      end
      total++;
      if ({busy_first, busy_last} !== 2'b11) begin
         bad++;
         $display("FAIL %s_busy_during: busy first/last=%b required 11", nm,
                  {busy_first, busy_last});
      end
      tick();
      total++;
      if (status_data[0] !== 1'b0 || txd !== 1'b1) begin
         bad++;
         $display("FAIL %s_idle_after: busy=%b txd=%b required 0 1", nm, status_data[0], txd);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) tick();
      total++;
      if (txd !== 1'b1 || status_data !== 16'h0002) begin
         bad++;
         $display("FAIL reset_held: txd=%b status=%h required 1 0002", txd, status_data);
      end
      reset = 1'b1;
      repeat (5) tick();
      total++;
      if (txd !== 1'b1 || status_data !== 16'h0002 || status_sel !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: txd=%b status=%h sel=%b required 1 0002 0",
                  txd, status_data, status_sel);
      end
   endtask

   task automatic test_single();
      send_and_check(16'hff00, 16'h0055, 2'b01, 8'h55, "single55");
   endtask

   task automatic test_lanes();
      send_and_check(16'hfeff, 16'ha5c3, 2'b11, 8'ha5, "hilane");
      send_and_check(16'hff00, 16'h3c41, 2'b11, 8'h41, "lolane");
      total++;
      if (status_data !== 16'h0002) begin
         bad++;
         $display("FAIL lanes_status: status=%h required 0002", status_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [199:0] cap, exp;
      logic [15:0]  st5;
      set_bus(16'hff00, 16'h0010, 2'b01);
      st5 = '0;
      for (int k = 0; k <= 200; k++) begin
         tick();
         if (k >= 1) cap[k-1] = txd;
         if (k == 5) st5 = status_data;
         if (k + 1 < 6) set_bus(16'hff00, 16'h0010 + 16'(k + 1), 2'b01);
         else dwrite_en = 2'b00;
      end
      for (int j = 0; j < 5; j++)
         for (int p = 0; p < 40; p++)
            exp[j*40 + p] = exp_bit(8'h10 + 8'(j), p);
      total++;
      if (st5 !== 16'h000d) begin
         bad++;
         $display("FAIL b2b_full_overflow: status=%h required 000d", st5);
      end
      total++;
      if (cap !== exp) begin
         bad++;
         $display("FAIL b2b_frames: txd samples=%h required %h", cap, exp);
      end
      tick();
      total++;
      if (status_data !== 16'h000a || txd !== 1'b1) begin
         bad++;
         $display("FAIL b2b_after: status=%h txd=%b required 000a 1", status_data, txd);
      end
      set_bus(16'hff01, 16'h0000, 2'b01);
      tick();
      dwrite_en = 2'b00;
      tick();
      total++;
      if (status_data !== 16'h0002) begin
         bad++;
         $display("FAIL ovf_clear: status=%h required 0002", status_data);
      end
   endtask

   task automatic test_reset_midframe();
      logic any_low, any_busy;
      set_bus(16'hff00, 16'h0081, 2'b01);
      tick();
      set_bus(16'hff00, 16'h0082, 2'b01);
      tick();
      set_bus(16'hff00, 16'h0083, 2'b01);
      tick();
      dwrite_en = 2'b00;
      // Now just after E2; advance to cycle 15 of the 0x81 frame (data bit 2 = 0).
      repeat (13) tick();
      total++;
      if (txd !== 1'b0 || status_data !== 16'h0001) begin
         bad++;
         $display("FAIL midframe_pre: txd=%b status=%h required 0 0001", txd, status_data);
      end
      reset = 1'b0;
      #1;
      total++;
      if (txd !== 1'b1 || status_data !== 16'h0002) begin
         bad++;
         $display("FAIL midframe_reset: txd=%b status=%h required 1 0002", txd, status_data);
      end
      repeat (3) tick();
      reset = 1'b1;
      any_low  = 1'b0;
      any_busy = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (txd !== 1'b1) any_low = 1'b1;
         if (status_data !== 16'h0002) any_busy = 1'b1;
      end
      total++;
      if (any_low || any_busy) begin
         bad++;
         $display("FAIL midframe_after: txd_low_seen=%b status_changed=%b required 0 0",
                  any_low, any_busy);
      end
   endtask

   task automatic test_miss();
      logic any_low;
      set_bus(16'hff02, 16'h0077, 2'b01);
      tick();
      set_bus(16'hfeff, 16'h0066, 2'b01);
      tick();
      set_bus(16'hff00, 16'h9900, 2'b10);
      tick();
      dwrite_en  = 2'b00;
      dread_addr = 16'hff01;
      any_low    = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (txd !== 1'b1) any_low = 1'b1;
      end
      total++;
      if (any_low || status_data !== 16'h0002) begin
         bad++;
         $display("FAIL miss_noframe: txd_low_seen=%b status=%h required 0 0002",
                  any_low, status_data);
      end
      total++;
      if (status_sel !== 1'b1) begin
         bad++;
         $display("FAIL miss_sel_hit: status_sel=%b required 1", status_sel);
      end
      dread_addr = 16'hff00;
      #1;
      total++;
      if (status_sel !== 1'b0) begin
         bad++;
         $display("FAIL miss_sel_off: status_sel=%b required 0", status_sel);
      end
   endtask

   initial begin
      reset       = 1'b0;
      dwrite_addr = '0;
      dwrite_data = '0;
      dwrite_en   = 2'b00;
      dread_addr  = '0;
      test_reset();
      test_single();
      test_lanes();
      test_back_to_back();
      test_reset_midframe();
      test_miss();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
